seq_par_counter_bank: RTL and testbench



---
 rtl/seq_par_counter_bank_if.sv | 38 +++
 rtl/seq_par_counter_bank.sv | 148 ++++++++++++++
 tb/tb_seq_par_counter_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_par_counter_bank_if.sv
// -----------------------------------------------------------------------------
// seq_par_counter_bank_if
// Control and status bundle for seq_par_counter_bank.
//   i_start    : request a run (honoured only while idle)
//   i_mode     : 0 = sequential schedule, 1 = parallel schedule
//   i_loop_cnt : iterations to run, 0 = free-run until i_stop
//   i_stop     : end the run at the next iteration boundary
//   i_clear    : zero all channels and the iteration count (idle only)
//   o_busy     : a run is in progress
//   o_done     : one-cycle pulse when a run has finished
//   o_iter     : completed iterations of the current/last run
//   o_ch_val   : channel i at bits [i*WIDTH +: WIDTH]
// The slave modport is the counter bank, the master modport its controller.
// -----------------------------------------------------------------------------
interface seq_par_counter_bank_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic                      i_start;
  logic                      i_mode;
  logic [7:0]                i_loop_cnt;
  logic                      i_stop;
  logic                      i_clear;
  logic                      o_busy;
  logic                      o_done;
  logic [7:0]                o_iter;
  logic [CHANNELS*WIDTH-1:0] o_ch_val;

  modport master (
    output i_start, i_mode, i_loop_cnt, i_stop, i_clear,
    input  o_busy, o_done, o_iter, o_ch_val
  );

  modport slave (
    input  i_start, i_mode, i_loop_cnt, i_stop, i_clear,
    output o_busy, o_done, o_iter, o_ch_val
  );
endinterface

// File: rtl/seq_par_counter_bank.sv
// -----------------------------------------------------------------------------
// seq_par_counter_bank
// Bank of CHANNELS counters of WIDTH bits, advanced by a small FSM under either
// a sequential schedule (one channel per cycle, each derived from its
// predecessor) or a parallel schedule (every channel each cycle), for a
// programmable number of iterations.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : control/status bundle (slave side), see seq_par_counter_bank_if
// -----------------------------------------------------------------------------
module seq_par_counter_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned INC      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_par_counter_bank_if.slave       bus
);

  localparam int unsigned SW = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN_SEQ = 2'd1,
    S_RUN_PAR = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ch [CHANNELS];
  logic [SW-1:0]    r_step;
  logic [7:0]       r_iter;
  logic [7:0]       r_loop_cnt;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_iter_next;
  logic             w_finish;
  logic             w_seq_last;

  // Parallel increment for channel idx, reduced mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] par_inc(input int unsigned idx);
    par_inc = WIDTH'(INC * (idx + 32'd1));
  endfunction

  // Iteration-boundary decode: a run ends on reaching loop_cnt or on stop.
  always_comb begin
    w_iter_next = r_iter + 8'd1;
    w_seq_last  = (r_step == SW'(CHANNELS - 1));
    if (((r_loop_cnt != 8'd0) && (w_iter_next == r_loop_cnt)) || bus.i_stop) begin
      w_finish = 1'b1;
    end else begin
      w_finish = 1'b0;
    end
  end

  // Sequencing FSM with channel, iteration and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_step     <= {SW{1'b0}};
      r_iter     <= 8'd0;
      r_loop_cnt <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_ch[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // clear takes priority; a simultaneous start is dropped
          if (bus.i_clear) begin
            r_iter <= 8'd0;
            for (int i = 0; i < CHANNELS; i++) begin
              r_ch[i] <= {WIDTH{1'b0}};
            end
          end else if (bus.i_start) begin
            r_loop_cnt <= bus.i_loop_cnt;
            r_iter     <= 8'd0;
            r_step     <= {SW{1'b0}};
            r_busy     <= 1'b1;
            r_state    <= bus.i_mode ? S_RUN_PAR : S_RUN_SEQ;
          end
        end

        S_RUN_SEQ: begin
          // Step s writes ch[s] from ch[s-1], which an earlier step of this
          // iteration already updated; step 0 feeds on itself.
          for (int i = 0; i < CHANNELS; i++) begin
            if (r_step == SW'(i)) begin
              r_ch[i] <= r_ch[(i == 0) ? 0 : i - 1] + WIDTH'(INC);
            end
          end
          if (w_seq_last) begin
            r_step <= {SW{1'b0}};
            r_iter <= w_iter_next;
            if (w_finish) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_step <= r_step + SW'(1);
          end
        end

        S_RUN_PAR: begin
          for (int i = 0; i < CHANNELS; i++) begin
            r_ch[i] <= r_ch[i] + par_inc(i);
          end
          r_iter <= w_iter_next;
          if (w_finish) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_step  <= {SW{1'b0}};
        end
      endcase
    end
  end

  // Status outputs come straight from registers.
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_iter = r_iter;

  // Pack channel registers onto the flat output bus.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign bus.o_ch_val[g*WIDTH +: WIDTH] = r_ch[g];
  end

endmodule

// File: tb/tb_seq_par_counter_bank.sv
// Directed bench for seq_par_counter_bank (WIDTH=8, CHANNELS=4, INC=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_seq_par_counter_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_par_counter_bank_if #(.WIDTH(8), .CHANNELS(4)) bus ();

  seq_par_counter_bank #(.WIDTH(8), .CHANNELS(4), .INC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run, then count cycles with busy high until it drops (bounded).
  task automatic do_run(input string tag, input logic mode, input logic [7:0] loops,
                        input int exp_busy, input int limit);
    int cnt;
    bus.i_mode     = mode;
    bus.i_loop_cnt = loops;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    cnt = 0;
    while (bus.o_busy && cnt < limit) begin
      check_val({tag, "_nodone"}, {63'd0, bus.o_done}, 64'd0);
      cnt++;
      tick();
    end
    check_val({tag, "_busycyc"}, 64'(cnt), 64'(exp_busy));
    check_val({tag, "_done"}, {63'd0, bus.o_done}, 64'd1);
    tick();
    check_val({tag, "_done1cyc"}, {63'd0, bus.o_done}, 64'd0);
    check_val({tag, "_idle"}, {63'd0, bus.o_busy}, 64'd0);
  endtask

  task automatic do_clear();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_mode     = 1'b0;
    bus.i_loop_cnt = 8'd0;
    bus.i_stop     = 1'b0;
    bus.i_clear    = 1'b0;

    // Reset state
    tick();
    rst = 1'b0;
    check_val("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    check_val("rst_done", {63'd0, bus.o_done}, 64'd0);
    check_val("rst_iter", 64'(bus.o_iter), 64'd0);
    check_val("rst_ch",   64'(bus.o_ch_val), 64'd0);

    // Sequential, one iteration: ch = [2,4,6,8]
    do_run("seq1", 1'b0, 8'd1, 4, 50);
    check_val("seq1_ch",   64'(bus.o_ch_val), 64'h08060402);
    check_val("seq1_iter", 64'(bus.o_iter), 64'd1);

    // Parallel, three iterations from reset: ch = [6,12,18,24]
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_run("par3", 1'b1, 8'd3, 3, 50);
    check_val("par3_ch",   64'(bus.o_ch_val), 64'h18120C06);
    check_val("par3_iter", 64'(bus.o_iter), 64'd3);

    // Sequential, two iterations, no clear: [8,10,12,14] then [10,12,14,16]
    bus.i_mode     = 1'b0;
    bus.i_loop_cnt = 8'd2;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    check_val("seq2_busy0", {63'd0, bus.o_busy}, 64'd1);
    check_val("seq2_iter0", 64'(bus.o_iter), 64'd0);
    repeat (4) tick();
    check_val("seq2_ch_it1",   64'(bus.o_ch_val), 64'h0E0C0A08);
    check_val("seq2_iter_it1", 64'(bus.o_iter), 64'd1);
    check_val("seq2_busy_it1", {63'd0, bus.o_busy}, 64'd1);
    repeat (4) tick();
    check_val("seq2_done", {63'd0, bus.o_done}, 64'd1);
    check_val("seq2_busy", {63'd0, bus.o_busy}, 64'd0);
    check_val("seq2_ch",   64'(bus.o_ch_val), 64'h100E0C0A);
    check_val("seq2_iter", 64'(bus.o_iter), 64'd2);
    tick();
    check_val("seq2_done1cyc", {63'd0, bus.o_done}, 64'd0);

    // Clear, then parallel 128 iterations: every channel wraps to 0
    do_clear();
    check_val("clr_ch",   64'(bus.o_ch_val), 64'd0);
    check_val("clr_iter", 64'(bus.o_iter), 64'd0);
    do_run("par128", 1'b1, 8'd128, 128, 400);
    check_val("par128_ch",   64'(bus.o_ch_val), 64'd0);
    check_val("par128_iter", 64'(bus.o_iter), 64'd128);

    // Free-run parallel, stop on 5th update, ignored start mid-run
    bus.i_mode     = 1'b1;
    bus.i_loop_cnt = 8'd0;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        bus.i_start    = 1'b1;
        bus.i_mode     = 1'b0;
        bus.i_loop_cnt = 8'd1;
      end else begin
        bus.i_start    = 1'b0;
      end
      tick();
    end
    bus.i_start = 1'b0;
    check_val("free_busy4", {63'd0, bus.o_busy}, 64'd1);
    check_val("free_ch4",   64'(bus.o_ch_val), 64'h20181008);
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    check_val("free_done", {63'd0, bus.o_done}, 64'd1);
    check_val("free_busy", {63'd0, bus.o_busy}, 64'd0);
    check_val("free_ch",   64'(bus.o_ch_val), 64'h281E140A);
    check_val("free_iter", 64'(bus.o_iter), 64'd5);
    tick();

    // Stop pulsed mid-iteration in sequential mode has no effect
    do_clear();
    bus.i_mode     = 1'b0;
    bus.i_loop_cnt = 8'd2;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    tick();
    bus.i_stop     = 1'b1;
    tick();
    bus.i_stop     = 1'b0;
    repeat (2) tick();
    check_val("seqstop_busy", {63'd0, bus.o_busy}, 64'd1);
    check_val("seqstop_iter", 64'(bus.o_iter), 64'd1);
    repeat (4) tick();
    check_val("seqstop_done", {63'd0, bus.o_done}, 64'd1);
    tick();

    // Mid-run reset during sequential step 2
    do_clear();
    bus.i_mode     = 1'b0;
    bus.i_loop_cnt = 8'd0;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    repeat (2) tick();
    check_val("mrst_pre_ch", 64'(bus.o_ch_val), 64'h00000402);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mrst_ch",   64'(bus.o_ch_val), 64'd0);
    check_val("mrst_iter", 64'(bus.o_iter), 64'd0);
    check_val("mrst_busy", {63'd0, bus.o_busy}, 64'd0);
    check_val("mrst_done", {63'd0, bus.o_done}, 64'd0);
    tick();
    check_val("mrst_done2", {63'd0, bus.o_done}, 64'd0);
    check_val("mrst_ch2",   64'(bus.o_ch_val), 64'd0);

    // Clear and start in the same idle cycle: clear wins, no run
    do_run("pre_cs", 1'b1, 8'd1, 1, 50);
    check_val("pre_cs_ch", 64'(bus.o_ch_val), 64'h08060402);
    bus.i_clear    = 1'b1;
    bus.i_start    = 1'b1;
    bus.i_mode     = 1'b1;
    bus.i_loop_cnt = 8'd1;
    tick();
    bus.i_clear    = 1'b0;
    bus.i_start    = 1'b0;
    check_val("cs_ch",   64'(bus.o_ch_val), 64'd0);
    check_val("cs_busy", {63'd0, bus.o_busy}, 64'd0);
    tick();
    check_val("cs_busy2", {63'd0, bus.o_busy}, 64'd0);
    check_val("cs_done2", {63'd0, bus.o_done}, 64'd0);
    check_val("cs_ch2",   64'(bus.o_ch_val), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
